// File: rtl/pulse_timing_gen.sv
// Laser-drive gate pulse generator fed by the I2C register bank.
// Timing values are shadowed at period boundaries; faults latch until cleared with the enable low.
`timescale 1ns/1ps
module pulse_timing_gen #(
   parameter int CNT_W       = 24,
   parameter int MIN_PERIOD  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] i_pulse_width,
   input  logic [CNT_W-1:0] i_period,
   input  logic [15:0]      i_static_control,
   input  logic [15:0]      i_dynamic_control,
   input  logic             i_fault_in,
   output logic             o_pulse_out,
   output logic             o_active,
   output logic [15:0]      o_pulse_count,
   output logic [7:0]       o_status
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_fault_sync;
   logic [1:0]             r_dyn_hist;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       r_pw_s;
   logic [CNT_W-1:0]       r_per_s;
   logic                   r_cont;
   logic                   r_cause_ext;
   logic                   r_cause_cfg;
   logic                   r_pulse_out;
   logic [15:0]            r_pulse_count;
   logic [7:0]             r_status;

   state_t                 w_nxt_state;
   logic [CNT_W-1:0]       w_nxt_cnt;
   logic [CNT_W-1:0]       w_nxt_pw_s;
   logic [CNT_W-1:0]       w_nxt_per_s;
   logic                   w_nxt_cont;
   logic                   w_nxt_cause_ext;
   logic                   w_nxt_cause_cfg;
   logic                   w_nxt_pulse_out;
   logic [15:0]            w_nxt_pulse_count;

   logic                   w_fsync;
   logic                   w_trig_p;
   logic                   w_clr_p;
   logic                   w_en;
   logic                   w_cfg_ok;
   logic                   w_wrap;
   logic                   w_unused;

   assign w_unused = ^{i_static_control[15:1], i_dynamic_control[15:2]};

   // Input conditioning: fault synchronizer and one-event-per-write edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fault_sync <= '0;
         r_dyn_hist   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         r_fault_sync <= {r_fault_sync[SYNC_STAGES-2:0], i_fault_in};
         r_dyn_hist   <= i_dynamic_control[1:0];
      end
   end

   assign w_fsync  = r_fault_sync[SYNC_STAGES-1];
   assign w_trig_p = i_dynamic_control[0] & ~r_dyn_hist[0];
   assign w_clr_p  = i_dynamic_control[1] & ~r_dyn_hist[1];
   assign w_en     = i_static_control[0];

   assign w_cfg_ok = (i_pulse_width != '0) &&
                     (i_pulse_width < i_period) &&
                     (i_period >= CNT_W'(MIN_PERIOD));

   assign w_wrap = (r_cnt == (r_per_s - CNT_W'(1)));

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_nxt_state       = r_state;
      w_nxt_cnt         = r_cnt;
      w_nxt_pw_s        = r_pw_s;
      w_nxt_per_s       = r_per_s;
      w_nxt_cont        = r_cont;
      w_nxt_cause_ext   = r_cause_ext;
      w_nxt_cause_cfg   = r_cause_cfg;
      w_nxt_pulse_count = r_pulse_count;
      w_nxt_pulse_out   = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_fsync) begin
               w_nxt_state     = FAULT;
               w_nxt_cause_ext = 1'b1;
            end else if (w_en || w_trig_p) begin
               if (w_cfg_ok) begin
                  w_nxt_state = RUN;
                  w_nxt_pw_s  = i_pulse_width;
                  w_nxt_per_s = i_period;
                  w_nxt_cnt   = '0;
                  w_nxt_cont  = w_en;
               end else begin
                  w_nxt_state     = FAULT;
                  w_nxt_cause_cfg = 1'b1;
               end
            end
         end

         RUN: begin
            // A fault outranks the period boundary and kills the gate on the next edge.
            if (w_fsync) begin
               w_nxt_state     = FAULT;
               w_nxt_cause_ext = 1'b1;
            end else begin
               w_nxt_pulse_out = (r_cnt < r_pw_s);
               w_nxt_cnt       = r_cnt + CNT_W'(1);
               if (w_wrap) begin
                  if (r_pulse_count != 16'hFFFF) begin
                     w_nxt_pulse_count = r_pulse_count + 16'd1;
                  end
                  if (r_cont && w_en && w_cfg_ok) begin
                     w_nxt_pw_s  = i_pulse_width;
                     w_nxt_per_s = i_period;
                     w_nxt_cnt   = '0;
                  end else if (r_cont && w_en) begin
                     w_nxt_state     = FAULT;
                     w_nxt_cause_cfg = 1'b1;
                  end else begin
                     w_nxt_state = IDLE;
                  end
               end
            end
         end

         FAULT: begin
            // Exit needs the enable low so a cleared fault cannot auto-restart.
            if (w_fsync) begin
               w_nxt_cause_ext = 1'b1;
            end else if (w_clr_p && !w_en) begin
               w_nxt_state       = IDLE;
               w_nxt_cause_ext   = 1'b0;
               w_nxt_cause_cfg   = 1'b0;
               w_nxt_pulse_count = '0;
            end
         end

         default: begin
            w_nxt_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_pw_s        <= '0;
         r_per_s       <= '0;
         r_cont        <= 1'b0;
         r_cause_ext   <= 1'b0;
         r_cause_cfg   <= 1'b0;
         r_pulse_out   <= 1'b0;
         r_pulse_count <= '0;
         r_status      <= '0;
      end else begin
         r_state       <= w_nxt_state;
         r_cnt         <= w_nxt_cnt;
         r_pw_s        <= w_nxt_pw_s;
         r_per_s       <= w_nxt_per_s;
         r_cont        <= w_nxt_cont;
         r_cause_ext   <= w_nxt_cause_ext;
         r_cause_cfg   <= w_nxt_cause_cfg;
         r_pulse_out   <= w_nxt_pulse_out;
         r_pulse_count <= w_nxt_pulse_count;
         r_status      <= {2'b00, w_en, r_cause_cfg, r_cause_ext,
                           (r_state == FAULT), r_pulse_out, (r_state == RUN)};
      end
   end

   assign o_pulse_out   = r_pulse_out;
   assign o_active      = (r_state == RUN);
   assign o_pulse_count = r_pulse_count;
   assign o_status      = r_status;

endmodule

// File: tb/tb_pulse_timing_gen.sv
// Directed bench for pulse_timing_gen: expectations queued with the stimulus, popped at each sample.
`timescale 1ns/1ps
module tb_pulse_timing_gen;

   localparam int CNT_W = 24;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [CNT_W-1:0] pulse_width = '0;
   logic [CNT_W-1:0] period = '0;
   logic [15:0]      static_control = '0;
   logic [15:0]      dynamic_control = '0;
   logic             fault_in = 1'b0;
   logic             pulse_out;
   logic             active;
   logic [15:0]      pulse_count;
   logic [7:0]       status;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   // Config legality table: pulse_width, period, legal.
   int cfg_pw  [6] = '{16, 0, 1, 1, 15, 17};
   int cfg_per [6] = '{16, 20, 15, 16, 16, 16};
   int cfg_ok  [6] = '{0, 0, 0, 1, 1, 0};

   always #5 clk = ~clk;

   pulse_timing_gen #(
      .CNT_W       (CNT_W),
      .MIN_PERIOD  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_pulse_width     (pulse_width),
      .i_period          (period),
      .i_static_control  (static_control),
      .i_dynamic_control (dynamic_control),
      .i_fault_in        (fault_in),
      .o_pulse_out       (pulse_out),
      .o_active          (active),
      .o_pulse_count     (pulse_count),
      .o_status          (status)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      static_control  = '0;
      dynamic_control = '0;
      fault_in        = 1'b0;
      pulse_width     = '0;
      period          = '0;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state.
      do_reset();
      expect_val("rst_pulse", 0);  check(pulse_out);
      expect_val("rst_active", 0); check(active);
      expect_val("rst_count", 0);  check(pulse_count);
      expect_val("rst_status", 0); check(status);

      // 1: continuous 4/16, enable dropped mid-pulse finishes the period.
      do_reset();
      pulse_width    = 4;
      period         = 16;
      static_control = 16'h0001;
      expect_val("t1_active_entry", 1);
      expect_val("t1_pulse_entry", 0);
      tick();
      check(active);
      check(pulse_out);
      for (int k = 2; k <= 49; k++) begin
         expect_val($sformatf("t1_pulse_k%0d", k), ((k - 2) % 16) < 4);
         if (k == 3) expect_val("t1_status_high", 8'h23);
         if (k == 17 || k == 33) expect_val($sformatf("t1_count_k%0d", k), (k - 1) / 16);
         if (k == 48) expect_val("t1_active_last", 1);
         if (k == 49) begin
            expect_val("t1_active_done", 0);
            expect_val("t1_count_done", 3);
         end
         tick();
         check(pulse_out);
         if (k == 3) check(status);
         if (k == 17 || k == 33) check(pulse_count);
         if (k == 48) check(active);
         if (k == 49) begin
            check(active);
            check(pulse_count);
         end
         if (k == 35) static_control = '0;
      end
      expect_val("t1_status_idle", 8'h00);
      tick();
      check(status);

      // 2: single shot from a 3-cycle trigger hold.
      do_reset();
      pulse_width     = 3;
      period          = 20;
      dynamic_control = 16'h0001;
      for (int k = 1; k <= 24; k++) begin
         expect_val($sformatf("t2_pulse_k%0d", k), (k >= 2) && (k <= 4));
         expect_val($sformatf("t2_active_k%0d", k), k <= 20);
         tick();
         check(pulse_out);
         check(active);
         if (k == 3) dynamic_control = '0;
      end
      expect_val("t2_count", 1);
      check(pulse_count);

      // 3: mid-period pulse_width write takes effect at the next period.
      do_reset();
      pulse_width    = 4;
      period         = 16;
      static_control = 16'h0001;
      for (int k = 1; k <= 34; k++) begin
         expect_val($sformatf("t3_pulse_k%0d", k),
                    (k >= 2) && ((k < 18) ? (((k - 2) % 16) < 4) : (((k - 18) % 16) < 8)));
         tick();
         check(pulse_out);
         if (k == 3) pulse_width = 8;
      end

      // 4: config legality boundaries.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         pulse_width     = CNT_W'(cfg_pw[i]);
         period          = CNT_W'(cfg_per[i]);
         dynamic_control = 16'h0001;
         expect_val($sformatf("t4_status_cfg%0d", i), (cfg_ok[i] != 0) ? 8'h01 : 8'h14);
         tick(2);
         check(status);
         dynamic_control = '0;
      end

      // 4b: config fault then clear with enable low.
      do_reset();
      pulse_width     = 16;
      period          = 16;
      dynamic_control = 16'h0001;
      tick(3);
      dynamic_control = '0;
      expect_val("t4_fault_status", 8'h14);
      expect_val("t4_fault_pulse", 0);
      check(status);
      check(pulse_out);
      tick(2);
      dynamic_control = 16'h0002;
      tick(2);
      expect_val("t4_clear_status", 8'h00);
      check(status);
      dynamic_control = '0;

      // 5: external fault during the 2nd high cycle of period two.
      do_reset();
      pulse_width    = 4;
      period         = 16;
      static_control = 16'h0001;
      tick(19);
      expect_val("t5_pulse_k19", 1);
      check(pulse_out);
      fault_in = 1'b1;
      tick();
      fault_in = 1'b0;
      expect_val("t5_pulse_k20", 1);
      check(pulse_out);
      tick();
      expect_val("t5_pulse_k21", 1);
      check(pulse_out);
      tick();
      expect_val("t5_pulse_k22", 0);
      expect_val("t5_active_k22", 0);
      expect_val("t5_count_k22", 1);
      check(pulse_out);
      check(active);
      check(pulse_count);
      tick();
      expect_val("t5_status_fault", 8'h2C);
      check(status);
      tick();
      dynamic_control = 16'h0002;
      tick(3);
      dynamic_control = '0;
      tick();
      expect_val("t5_status_blocked", 8'h2C);
      expect_val("t5_active_blocked", 0);
      check(status);
      check(active);
      static_control  = '0;
      dynamic_control = 16'h0002;
      tick();
      expect_val("t5_count_cleared", 0);
      check(pulse_count);
      tick();
      expect_val("t5_status_cleared", 8'h00);
      check(status);
      dynamic_control = '0;

      // 6: asynchronous reset mid-pulse, restart with enable held.
      do_reset();
      pulse_width    = 4;
      period         = 16;
      static_control = 16'h0001;
      tick(3);
      expect_val("t6_pulse_before", 1);
      check(pulse_out);
      rst = 1'b1;
      #1;
      expect_val("t6_pulse_async", 0);
      expect_val("t6_active_async", 0);
      check(pulse_out);
      check(active);
      tick(2);
      rst = 1'b0;
      tick();
      expect_val("t6_active_restart", 1);
      expect_val("t6_pulse_restart", 0);
      check(active);
      check(pulse_out);
      for (int j = 2; j <= 7; j++) begin
         expect_val($sformatf("t6_pulse_j%0d", j), j <= 5);
         tick();
         check(pulse_out);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
